// File: rtl/freq_counter_axi_lite_slave.sv
`default_nettype none
//============================================================================
// Module   : freq_counter_axi_lite_slave
// Brief    : AXI4-Lite slave terminating the FreqCounter S00_AXI port.
//            Four 32-bit R/W registers with byte-lane strobes, exported to
//            the counter core together with a one-cycle write pulse per
//            register. Write address and write data are buffered in
//            independent single-entry holding registers so they may arrive
//            in any order; a write commits once both are held and the
//            response channel is free.
// Revision : 1.0 - initial release
//============================================================================
module freq_counter_axi_lite_slave #(
  parameter integer C_S_AXI_DATA_WIDTH = 32,
  parameter integer C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  // Write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  // Write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  // Write response channel
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  // Read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  // Read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  // Register outputs to the counter core
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3,
  output logic [3:0]                        reg_wr_pulse
);

  localparam integer C_NUM_REGS = 4;
  localparam integer C_IDX_W    = 2;
  localparam integer C_IDX_LSB  = 2;  // word-aligned: byte offset bits ignored
  localparam integer C_STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] C_RESP_OKAY = 2'b00;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                          aw_full_q,  aw_full_d;
  logic [C_IDX_W-1:0]            aw_idx_q,   aw_idx_d;
  logic                          w_full_q,   w_full_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q,   w_data_d;
  logic [C_STRB_W-1:0]           w_strb_q,   w_strb_d;
  logic                          bvalid_q,   bvalid_d;
  logic                          rvalid_q,   rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [C_NUM_REGS-1:0]         pulse_q,    pulse_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];

  // --------------------------------------------------------------------------
  // Handshake and commit qualifiers
  // --------------------------------------------------------------------------
  logic               awready;
  logic               wready;
  logic               arready;
  logic               aw_hs;
  logic               w_hs;
  logic               ar_hs;
  logic               r_hs;
  logic               commit;
  logic [C_IDX_W-1:0] ar_idx;

  // Readiness is gated by reset so no handshake can occur while it is held.
  assign awready = !aw_full_q && !S_AXI_ARESET;
  assign wready  = !w_full_q  && !S_AXI_ARESET;
  assign arready = !rvalid_q  && !S_AXI_ARESET;

  assign aw_hs = S_AXI_AWVALID && awready;
  assign w_hs  = S_AXI_WVALID  && wready;
  assign ar_hs = S_AXI_ARVALID && arready;
  assign r_hs  = rvalid_q && S_AXI_RREADY;

  // A write retires once both halves are held and the B channel can take a
  // new response (either idle, or its current response is being accepted).
  assign commit = aw_full_q && w_full_q && (!bvalid_q || S_AXI_BREADY);

  assign ar_idx = S_AXI_ARADDR[C_IDX_LSB +: C_IDX_W];

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[C_IDX_LSB-1:0],
                           S_AXI_ARADDR[C_IDX_LSB-1:0]};

  // Write-path next state: capture AW/W independently, release on commit.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    pulse_d   = '0;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_IDX_LSB +: C_IDX_W];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    // Response clears on acceptance; a same-cycle commit re-arms it.
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      pulse_d   = {{(C_NUM_REGS-1){1'b0}}, 1'b1} << aw_idx_q;
    end
  end

  // Register-file next state: byte-lane merge of held data on commit.
  always_comb begin
    for (int r = 0; r < C_NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (commit) begin
      for (int k = 0; k < C_STRB_W; k++) begin
        if (w_strb_q[k]) begin
          regs_d[aw_idx_q][8*k +: 8] = w_data_q[8*k +: 8];
        end
      end
    end
  end

  // Read-path next state: sample the register file on AR handshake, which
  // sees pre-commit contents if a write lands on the same edge.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (r_hs) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[ar_idx];
    end
  end

  // State registers with synchronous reset; any in-flight write is dropped.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int r = 0; r < C_NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      pulse_q   <= pulse_d;
      for (int r = 0; r < C_NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BRESP   = C_RESP_OKAY;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RRESP   = C_RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign slv_reg0      = regs_q[0];
  assign slv_reg1      = regs_q[1];
  assign slv_reg2      = regs_q[2];
  assign slv_reg3      = regs_q[3];
  assign reg_wr_pulse  = pulse_q;

endmodule
`default_nettype wire

// File: doc/freq_counter_axi_lite_slave.md
# freq_counter_axi_lite_slave

AXI4-Lite slave register block that terminates the S00_AXI port of the FreqCounter IP. It responds to the master agent's single-beat AXI4-Lite writes and reads. It holds four 32-bit read/write registers and presents them, plus a per-register write pulse, to the frequency-counter core. It sits between the block-design AXI interconnect and the counter logic inside the IP.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decodes 4 word registers.

Ports:
- Clocking and reset: one clock, S_AXI_ACLK; reset is synchronous and active-high, S_AXI_ARESET.
- S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
- S_AXI_ARESET  in  1  synchronous active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte-lane enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- slv_reg0..slv_reg3  out  32 each  current register contents, to the counter core.
- reg_wr_pulse  out  4  bit i high for one cycle after register i is written.

## Operation
- Register index is addr[3:2]; addr[1:0] are ignored. There are no unmapped addresses, so no SLVERR.
- Write path: separate single-entry holding registers aw_full/aw_addr and w_full/w_data/w_strb.
  - AWREADY = !aw_full && !S_AXI_ARESET; WREADY = !w_full && !S_AXI_ARESET.
  - AW and W are accepted independently, in either order, in the same or different cycles.
- Commit: when aw_full && w_full && (!BVALID || BREADY) in a cycle:
  - at that edge, each byte lane k of reg[aw_addr[3:2]] with w_strb[k]=1 takes w_data[8k+7:8k]; other lanes hold;
  - aw_full and w_full clear, BVALID is set, and reg_wr_pulse[idx] is set for exactly one cycle.
  - A write with WSTRB=0 still completes and pulses reg_wr_pulse; the register is unchanged.
- BVALID holds until BREADY is sampled high. If BREADY is low, the next AW/W may still be captured into the holding registers, but commit waits.
- Read path: ARREADY = !RVALID && !S_AXI_ARESET.
  - On the AR handshake edge, RDATA is loaded with reg[araddr[3:2]] and RVALID is set.
  - RDATA is stable while RVALID && !RREADY. RVALID clears on the RVALID && RREADY edge.
- Read and write are fully independent. If an AR handshake and a commit to the same register occur on the same edge, RDATA returns the pre-write value.
- Reset (any cycle, including mid-transaction) clears:
  - all four registers to 0;
  - aw_full, w_full, BVALID, RVALID, RDATA and reg_wr_pulse to 0.
  - A partially received write is discarded; no response is issued for it.

## Timing
- Reset values:
  - AWREADY, WREADY and ARREADY are 0 while S_AXI_ARESET=1, and 1 in the first cycle after reset deasserts.
  - BVALID, RVALID, RDATA, reg_wr_pulse and slv_reg0..3 are all 0; BRESP and RRESP are 00.
- Write latency: AW and W handshakes both at edge N → commit condition true in cycle N+1 → register updated, BVALID=1 and pulse=1 in cycle N+2.
- If AW and W arrive at different edges, latency is counted from the later handshake.
- Write throughput: one write per 2 cycles with BREADY tied high.
- Read latency: AR handshake at edge N → RVALID=1 with valid RDATA in cycle N+1.
- Read throughput: with RREADY high, ARREADY returns high the cycle after the R handshake, giving one read per 2 cycles.
- slv_regX reflects a write in the same cycle that BVALID rises.

## Test plan
- Reset, then sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back in order:
  - each BRESP=00;
  - reads return 1, 2, 3, 4;
  - reg_wr_pulse asserts 4'b0001, 4'b0010, 4'b0100, 4'b1000, one cycle each.
- Write 0xFFFFFFFF to 0x4, then 0xAABBCCDD with WSTRB=4'b0101 → read 0x4 returns 0xFFBBFFDD.
- W presented 3 cycles before AW to 0x8 with data 0x12345678:
  - WREADY is accepted immediately and then goes low;
  - BVALID rises 2 cycles after the AW handshake;
  - slv_reg2=0x12345678.
- BREADY held low for 10 cycles after the first write, with a second write presented:
  - the second AW/W are captured, AWREADY/WREADY then go low, slv_reg is unchanged;
  - commit and second BVALID follow one cycle after the first B handshake.
- RREADY held low for 5 cycles on a read of 0xC → RDATA stable at 4 and ARREADY low throughout.
- Assert S_AXI_ARESET after the AW handshake but before W:
  - no BVALID is issued;
  - all registers read 0 afterward;
  - a subsequent full write of 0x55 to 0x0 completes normally.
